alu_seq: RTL and testbench

Accumulator-based command sequencer that drives the 8-bit combinational ALU. Accepts one command at a time over a valid/ready handshake, presents registered `op1`/`op2`/`code` to the ALU, captures the ALU result into an internal 8-bit accumulator, and returns the result over a second valid/ready handshake. It sits between a host command source and the ALU and chains operations through the accumulator.

---
 rtl/alu_seq.sv | 132 +++++++++++++
 tb/tb_alu_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Accumulator-based command sequencer feeding an external combinational 8-bit ALU.
// Optional zero/negative flags are compiled in with `define ALU_SEQ_FLAGS_EN.
module alu_seq #(
  parameter int                 DATA_W   = 8,
  parameter logic [DATA_W-1:0]  ACC_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [3:0]        cmd_code,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [4:0]        code,
  input  logic [DATA_W-1:0] alu_res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n
`endif
);

  localparam logic [3:0] CODE_DIV = 4'h3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc;
  logic              issue;
  logic              acc_ld_imm;
  logic              acc_ld_alu;
  logic              err_set;
  logic              err_clr;

  // The only arithmetic the sequencer owns: rejecting a divide by zero
  // before it ever reaches the ALU.
  function automatic logic is_div_zero(input logic [3:0] c, input logic [DATA_W-1:0] imm);
    return (c == CODE_DIV) && (imm == '0);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    acc_ld_imm = 1'b0;
    acc_ld_alu = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_load) begin
            acc_ld_imm = 1'b1;
            err_clr    = 1'b1;
            state_nxt  = DONE;
          end else if (is_div_zero(cmd_code, cmd_imm)) begin
            err_set    = 1'b1;
            state_nxt  = DONE;
          end else begin
            issue      = 1'b1;
            err_clr    = 1'b1;
            state_nxt  = EXEC;
          end
        end
      end
      EXEC: begin
        acc_ld_alu = 1'b1;
        state_nxt  = DONE;
      end
      DONE: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALU operand registers stay put outside an issue so the ALU output is stable in EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= ACC_INIT;
      op1     <= '0;
      op2     <= '0;
      code    <= '0;
      res_err <= 1'b0;
    end else begin
      if (issue) begin
        op1  <= acc;
        op2  <= cmd_imm;
        code <= {1'b0, cmd_code};
      end
      if (acc_ld_imm)      acc <= cmd_imm;
      else if (acc_ld_alu) acc <= alu_res;
      if (err_set)         res_err <= 1'b1;
      else if (err_clr)    res_err <= 1'b0;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  // Flags track every accumulator write; a rejected divide leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (acc_ld_imm) begin
      flag_z <= (cmd_imm == '0);
      flag_n <= cmd_imm[DATA_W-1];
    end else if (acc_ld_alu) begin
      flag_z <= (alu_res == '0);
      flag_n <= alu_res[DATA_W-1];
    end
  end
`endif

  assign cmd_ready = (state == IDLE);
  assign res_valid = (state == DONE);
  assign res_data  = acc;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with a small behavioural ALU attached.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_load;
  logic [3:0] cmd_code;
  logic [7:0] cmd_imm;
  logic [7:0] op1, op2;
  logic [4:0] code;
  logic [7:0] alu_res;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       res_err;
`ifdef ALU_SEQ_FLAGS_EN
  logic       flag_z, flag_n;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_code  (cmd_code),
    .cmd_imm   (cmd_imm),
    .op1       (op1),
    .op2       (op2),
    .code      (code),
    .alu_res   (alu_res),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flag_z    (flag_z),
    .flag_n    (flag_n)
`endif
  );

  // Stand-in for the ALU: only the operations this bench exercises
  always_comb begin
    alu_res = 8'h00;
    case (code)
      5'h00: alu_res = op1 + op2;
      5'h01: alu_res = op1 - op2;
      5'h03: alu_res = (op2 != 8'h00) ? op1 / op2 : 8'h00;
      5'h08: alu_res = op1 ^ op2;
      5'h0C: alu_res = op1 << op2[2:0];
      default: alu_res = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [3:0] c, input logic [7:0] imm);
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_code  = c;
    cmd_imm   = imm;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_code  = 4'h0;
    cmd_imm   = 8'h00;
    res_ready = 1'b0;
    repeat (3) tick();
    check("rst_acc",       res_data,  8'h00);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_code",      code,      5'h00);
    check("rst_op1",       op1,       8'h00);
    check("rst_op2",       op2,       8'h00);
    check("rst_err",       res_err,   1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", cmd_ready, 1'b1);

    // load 0x05, add 0x03
    drive(1'b1, 4'h0, 8'h05);
    check("ld5_valid", res_valid, 1'b1);
    check("ld5_data",  res_data,  8'h05);
    accept();
    drive(1'b0, 4'h0, 8'h03);
    check("add_exec_valid", res_valid, 1'b0);
    check("add_exec_ready", cmd_ready, 1'b0);
    check("add_op1",  op1,  8'h05);
    check("add_op2",  op2,  8'h03);
    check("add_code", code, 5'h00);
    tick();
    check("add_valid", res_valid, 1'b1);
    check("add_data",  res_data,  8'h08);
    check("add_err",   res_err,   1'b0);
    accept();
    check("add_back_idle", cmd_ready, 1'b1);

    // load 0x10, sub 0x20 -> 0xF0, then xor 0xF0 -> 0x00
    drive(1'b1, 4'h0, 8'h10);
    accept();
    drive(1'b0, 4'h1, 8'h20);
    check("sub_code", code, 5'h01);
    tick();
    check("sub_data", res_data, 8'hF0);
`ifdef ALU_SEQ_FLAGS_EN
    check("sub_flag_n", flag_n, 1'b1);
    check("sub_flag_z", flag_z, 1'b0);
`endif
    accept();
    drive(1'b0, 4'h8, 8'hF0);
    tick();
    check("xor_data", res_data, 8'h00);
`ifdef ALU_SEQ_FLAGS_EN
    check("xor_flag_z", flag_z, 1'b1);
    check("xor_flag_n", flag_n, 1'b0);
`endif
    accept();

    // divide by zero with acc = 0x40
    drive(1'b1, 4'h0, 8'h40);
    accept();
    drive(1'b0, 4'h3, 8'h00);
    check("div0_valid", res_valid, 1'b1);
    check("div0_err",   res_err,   1'b1);
    check("div0_data",  res_data,  8'h40);
    check("div0_op1",   op1,       8'hF0);
    check("div0_op2",   op2,       8'hF0);
    check("div0_code",  code,      5'h08);
    accept();
    drive(1'b0, 4'h0, 8'h01);
    tick();
    check("post_div0_data", res_data, 8'h41);
    check("post_div0_err",  res_err,  1'b0);
    accept();

    // backpressure with cmd_valid held high throughout
    cmd_valid = 1'b1;
    cmd_load  = 1'b0;
    cmd_code  = 4'h0;
    cmd_imm   = 8'h02;
    tick();
    cmd_imm   = 8'h55;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", res_valid, 1'b1);
      check("bp_data",  res_data,  8'h43);
      check("bp_ready", cmd_ready, 1'b0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_released_ready", cmd_ready, 1'b1);
    check("bp_released_valid", res_valid, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("bp_next_op1", op1, 8'h43);
    check("bp_next_op2", op2, 8'h55);
    tick();
    check("bp_next_data", res_data, 8'h98);
    accept();

    // reset while EXEC is in flight
    drive(1'b1, 4'h0, 8'h07);
    accept();
    drive(1'b0, 4'hC, 8'h01);
    check("shl_exec_op1",  op1,  8'h07);
    check("shl_exec_code", code, 5'h0C);
    rst_n = 1'b0;
    #1;
    check("midrst_acc",   res_data,  8'h00);
    check("midrst_valid", res_valid, 1'b0);
    check("midrst_ready", cmd_ready, 1'b1);
    check("midrst_op1",   op1,       8'h00);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("midrst_hold_data", res_data, 8'h00);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postrst_valid", res_valid, 1'b0);
      check("postrst_data",  res_data,  8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
